// File: rtl/alu_operand_seq.sv
// Operand-entry sequencer for the 4-bit sign-magnitude ALU: captures A, B and
// the opcode on successive debounced button presses, then holds them as valid.
module alu_operand_seq #(
    parameter int DB_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_sw,
    input  logic [2:0] i_op_sw,
    input  logic       i_btn,
    input  logic       i_clr,
    output logic [3:0] o_a,
    output logic [3:0] o_b,
    output logic [2:0] o_op,
    output logic       o_valid,
    output logic [1:0] o_stage,
    output logic       o_load
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    logic          btn_meta_q, btn_meta_d;
    logic          btn_s_q, btn_s_d;
    logic          clr_meta_q, clr_meta_d;
    logic          clr_s_q, clr_s_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic          valid_q, valid_d;
    logic          load_q, load_d;
    logic          press;

    always_comb begin
        btn_meta_d = i_btn;
        btn_s_d    = btn_meta_q;
        clr_meta_d = i_clr;
        clr_s_d    = clr_meta_q;
    end

    // Debouncer: any sample agreeing with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (btn_s_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = btn_s_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign press = ~stable_q & btn_s_q & (cnt_q == CNT_MAX);

    // Clear wins over a press landing on the same edge; that press is dropped.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = valid_q;
        load_d  = 1'b0;
        if (clr_s_q) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            valid_d = 1'b0;
        end else if (press) begin
            case (state_q)
                S_A: begin
                    a_d     = i_sw;
                    valid_d = 1'b0;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = i_sw;
                    state_d = S_OP;
                end
                S_OP: begin
                    op_d    = i_op_sw;
                    valid_d = 1'b1;
                    load_d  = 1'b1;
                    state_d = S_SHOW;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            clr_meta_q <= 1'b0;
            clr_s_q    <= 1'b0;
            stable_q   <= 1'b0;
            cnt_q      <= '0;
            state_q    <= S_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            valid_q    <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_s_q    <= btn_s_d;
            clr_meta_q <= clr_meta_d;
            clr_s_q    <= clr_s_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            valid_q    <= valid_d;
            load_q     <= load_d;
        end
    end

    assign o_a     = a_q;
    assign o_b     = b_q;
    assign o_op    = op_q;
    assign o_valid = valid_q;
    assign o_stage = state_q;
    assign o_load  = load_q;

endmodule

// File: doc/alu_operand_seq.md
# alu_operand_seq

Operand-entry sequencer sitting directly upstream of the 4-bit sign-magnitude ALU. It captures operand A, operand B and the 3-bit opcode from board switches on successive presses of a single debounced push-button. It then holds all three stable at the ALU inputs while flagging the result as valid. A second input gives a synchronous clear back to the start of entry.

## Interface
- `DB_CYCLES`, default 20000: consecutive stable cycles required to accept a button level change; legal range ≥ 2.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_sw` input 4: operand switches, sign-magnitude (bit 3 = sign); treated as quasi-static, sampled only on a capture event.
- `i_op_sw` input 3: opcode switches; sampled only on a capture event.
- `i_btn` input 1: raw step button, asynchronous, bouncy, active-high.
- `i_clr` input 1: raw clear switch, asynchronous, active-high, level.
- `o_a` output 4: captured operand A, drives ALU `i_a`.
- `o_b` output 4: captured operand B, drives ALU `i_b`.
- `o_op` output 3: captured opcode, drives ALU `i_op`.
- `o_valid` output 1: high while all three fields belong to one completed entry.
- `o_stage` output 2: current entry stage, for status LEDs. 00 = awaiting A, 01 = awaiting B, 10 = awaiting op, 11 = showing.
- `o_load` output 1: one-cycle pulse on the cycle the entry completes.

## Operation
- **Button path**
  - 2-FF synchronizer produces `btn_s`.
  - Debouncer keeps a `stable` level and a counter, width ceil(log2(DB_CYCLES)).
  - Counter clears whenever `btn_s == stable`; otherwise it increments.
  - When the counter equals DB_CYCLES-1 and `btn_s != stable`, `stable <= btn_s` and the counter clears.
  - A press event is the edge on which `stable` goes 0→1. Release (1→0) is debounced but causes no action.
- **Clear path**: 2-FF synchronizer produces `clr_s`. No debounce.
- **FSM states**: S_A(00), S_B(01), S_OP(10), S_SHOW(11). `o_stage` is the state encoding.
- **Transitions on a press event**
  - S_A: `o_a <= i_sw`, `o_valid <= 0`, next S_B.
  - S_B: `o_b <= i_sw`, next S_OP.
  - S_OP: `o_op <= i_op_sw`, `o_valid <= 1`, `o_load` pulses, next S_SHOW.
  - S_SHOW: `o_valid <= 0`, next S_A. `o_a`, `o_b` and `o_op` keep their old values until overwritten.
- With no press event, state and all captured fields hold. Switch changes never alter outputs outside a capture edge.
- **Clear**: while `clr_s` = 1, state is forced to S_A, `o_a`/`o_b`/`o_op` = 0, `o_valid` = 0 and `o_load` = 0.
  - Clear beats a simultaneous press event; that press is discarded.
  - The debouncer keeps running during clear, so a button held through clear release does not create a press.
- No arithmetic is done here. Fields pass through unmodified, including sign-magnitude -0 (4'b1000).

## Timing
- **Reset**: `o_a` = 0, `o_b` = 0, `o_op` = 0, `o_valid` = 0, `o_load` = 0, `o_stage` = 00. Synchronizers, `stable` and the counter are all cleared.
- Reset mid-entry abandons the partial entry without any output glitch beyond returning to reset values.
- **Press latency**: `i_btn` high from before rising edge k, held steady → press event at edge k+DB_CYCLES+1. Outputs update on that edge.
- A bounce that returns `btn_s` to `stable` before the count completes restarts the count from 0.
- **`o_load`** is high for exactly the cycle after the S_OP→S_SHOW edge. At most one pulse per physical press.
- **Clear latency**: `i_clr` high before edge k → forced state visible after edge k+2.
- All outputs are registered and have no combinational path from any input.

## Test plan
- DB_CYCLES=4. Reset, release, then three clean presses with `i_sw` = 4'b0011, 4'b1010 and `i_op_sw` = 3'b001. Required: `o_a` = 3, `o_b` = 4'b1010, `o_op` = 1, `o_valid` = 1, one `o_load` pulse, `o_stage` = 11.
- Bounce `i_btn` 1/0 every cycle for 10 cycles, then hold high. Required: exactly one press event, at hold-start edge +5. `o_stage` advances by exactly one.
- In S_SHOW, toggle `i_sw` and `i_op_sw` freely. Required: outputs unchanged. A fourth press gives `o_valid` = 0, `o_stage` = 00, `o_a` still 3.
- Assert `i_clr` in S_OP on the same edge a press completes. Required: `o_stage` = 00, all fields 0, no `o_load`. Release `i_clr` with the button still held: no press event.
- Assert `rst_n` low mid-debounce with the counter at 2. Required: immediate reset values, then the next full press captures A normally.
- Enter A = 4'b1000 (-0). Required: `o_a` = 4'b1000 passed through unmodified.
